dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Miss/write sequencer for the 2-way, 4-set MEM-stage data cache. Sits between the MEM
//  stage, the cache array (hit/rdata/dwe port) and multi-cycle main RAM (req/ack bus).
//  Read hits complete with no stall. Read misses fetch from RAM and fill the cache.
//  Stores are write-through with write-allocate. The pipeline is stalled until each
//  transaction retires.
// PARAMETERS
//  ADDR_W   8    address width (cache tag+set)
//  DATA_W   16   data word width
//  TIMEOUT  15   max cycles waiting for ram_ack before bus error (1..255)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       reset, synchronous, active-low
//  mem_rd      in   1       MEM stage load request (level, held while stall=1)
//  mem_wr      in   1       MEM stage store request (level, held while stall=1)
//  mem_addr    in   ADDR_W  load/store address
//  mem_wdata   in   DATA_W  store data
//  cache_hit   in   1       cache lookup hit for cache_addr
//  cache_rdata in   DATA_W  cache read data for cache_addr
//  cache_addr  out  ADDR_W  cache address: mem_addr in IDLE, latched address otherwise
//  cache_we    out  1       cache fill strobe (cache dwe), one cycle
//  cache_wdata out  DATA_W  fill data (latched)
//  ram_req     out  1       RAM request, held until ram_ack
//  ram_we      out  1       RAM write qualifier (valid with ram_req)
//  ram_addr    out  ADDR_W  RAM address (latched)
//  ram_wdata   out  DATA_W  RAM write data (latched)
//  ram_ack     in   1       RAM done; read data valid same cycle
//  ram_rdata   in   DATA_W  RAM read data
//  rdata       out  DATA_W  load result to MEM/WB
//  stall       out  1       freeze pipeline
//  bus_err     out  1       one-cycle pulse on RAM timeout
//  hit_cnt     out  16      load hit count
//  miss_cnt    out  16      load miss count
// BEHAVIOUR
//  - FSM states: IDLE, RD_REQ, WR_REQ, FILL, DONE. All state and latches are flops.
//    Every output is decoded from state and latches, except for the IDLE terms below.
//  - IDLE:
//    - mem_wr=1: latch addr/wdata, go to WR_REQ. mem_wr beats mem_rd when both are set.
//    - mem_rd=1 and cache_hit=0: latch addr, go to RD_REQ.
//    - mem_rd=1 and cache_hit=1: stay in IDLE; rdata=cache_rdata combinationally; no stall.
//  - RD_REQ: ram_req=1, ram_we=0. On ram_ack, latch ram_rdata and go to FILL.
//  - WR_REQ: ram_req=1, ram_we=1. On ram_ack go to FILL (fill data = store data).
//  - FILL: cache_we=1 for exactly one cycle, then go to DONE.
//  - DONE: stall=0; rdata=latched data for this cycle; then go to IDLE.
//  - stall = (IDLE & (mem_wr | mem_rd & ~cache_hit)) | RD_REQ | WR_REQ | FILL.
//  - Latency with ack on first request cycle: read miss 3 stall cycles; store 3 stall cycles.
//  - Timeout: an 8-bit counter clears on entering RD_REQ/WR_REQ and increments each cycle
//    without ack. At count==TIMEOUT-1 with no ack: go to DONE, skip FILL (no cache
//    update), rdata=all ones, pulse bus_err in that DONE cycle.
//  - ram_ack outside RD_REQ/WR_REQ is ignored.
//  - rdata is 0 in all states except IDLE-hit and DONE.
//  - Reset (rst=0 at a clk edge), including mid-transaction: next state is IDLE. Latches,
//    counter and stat counters clear. ram_req, ram_we, cache_we, bus_err, stall and rdata
//    are 0 after the edge. An abandoned RAM transaction is not resumed.
// CONFIGURATION
//  - DCACHE_STAT_EN defined:
//    - hit_cnt increments on each IDLE read hit retire.
//    - miss_cnt increments on each RD_REQ entry.
//    - Both are 16-bit and saturate at 16'hFFFF.
//  - DCACHE_STAT_EN undefined: counters not built; hit_cnt=miss_cnt=0; ports remain.
// TESTING
//  1. rst=0 for 2 cycles, then 1 -> state IDLE; stall, ram_req, cache_we, rdata all 0.
//  2. mem_rd, addr 8'h14, cache_hit=1, cache_rdata=16'hBEEF -> rdata=16'hBEEF same cycle;
//     stall=0; no ram_req.
//  3. mem_rd, addr 8'h21, hit=0, ram_ack on 2nd req cycle with ram_rdata=16'h1234:
//     - stall is 1 for 4 cycles;
//     - cache_we is 1 for one cycle with cache_wdata=16'h1234;
//     - the DONE cycle gives rdata=16'h1234.
//  4. mem_wr, addr 8'h07, data 16'hA5A5, with mem_rd also high:
//     - ram_req=1, ram_we=1, ram_addr=8'h07, ram_wdata=16'hA5A5;
//     - after ack, cache_we pulses with 16'hA5A5;
//     - no read request is issued.
//  5. Read miss with ram_ack never asserted, TIMEOUT=15:
//     - after 15 RD_REQ cycles: bus_err=1 for one cycle, rdata=16'hFFFF;
//     - cache_we never pulses; then IDLE.
//  6. rst=0 during WR_REQ -> next cycle IDLE, ram_req=0, stall=0.
//     With DCACHE_STAT_EN: after 3 hits and 2 misses, hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Bundle of MEM-stage, cache-array and RAM-bus signals for dcache_ctrl.
// Suffixes _i/_o are from the controller's point of view.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_rd_i;
    logic              mem_wr_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              cache_hit_i;
    logic [DATA_W-1:0] cache_rdata_i;
    logic [ADDR_W-1:0] cache_addr_o;
    logic              cache_we_o;
    logic [DATA_W-1:0] cache_wdata_o;
    logic              ram_req_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic              ram_ack_i;
    logic [DATA_W-1:0] ram_rdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              stall_o;
    logic              bus_err_o;
    logic [15:0]       hit_cnt_o;
    logic [15:0]       miss_cnt_o;

    modport slave (
        input  mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i,
        input  cache_hit_i, cache_rdata_i, ram_ack_i, ram_rdata_i,
        output cache_addr_o, cache_we_o, cache_wdata_o,
        output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output rdata_o, stall_o, bus_err_o, hit_cnt_o, miss_cnt_o
    );

    modport master (
        output mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i,
        output cache_hit_i, cache_rdata_i, ram_ack_i, ram_rdata_i,
        input  cache_addr_o, cache_we_o, cache_wdata_o,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  rdata_o, stall_o, bus_err_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Miss/write-through sequencer for the MEM-stage data cache, with RAM timeout.
// Optional hit/miss statistics counters are built when DCACHE_STAT_EN is defined.
module dcache_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, FILL, DONE} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              idle, rd_hit, rd_miss;

    assign idle    = (state_q == IDLE);
    assign rd_hit  = idle && !bus.mem_wr_i && bus.mem_rd_i &&  bus.cache_hit_i;
    assign rd_miss = idle && !bus.mem_wr_i && bus.mem_rd_i && !bus.cache_hit_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_wr_i) begin
                    addr_d  = bus.mem_addr_i;
                    data_d  = bus.mem_wdata_i;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = WR_REQ;
                end else if (rd_miss) begin
                    addr_d  = bus.mem_addr_i;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                if (bus.ram_ack_i) begin
                    if (state_q == RD_REQ) data_d = bus.ram_rdata_i;
                    state_d = FILL;
                end else if (tmo_q == TMO_LAST) begin
                    // Timeout skips FILL so the cache is never updated with error data.
                    data_d  = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            FILL: state_d = DONE;
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cache_addr_o  = idle ? bus.mem_addr_i : addr_q;
    assign bus.cache_we_o    = (state_q == FILL);
    assign bus.cache_wdata_o = data_q;
    assign bus.ram_req_o     = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus.ram_we_o      = (state_q == WR_REQ);
    assign bus.ram_addr_o    = addr_q;
    assign bus.ram_wdata_o   = data_q;
    assign bus.bus_err_o     = (state_q == DONE) && err_q;
    assign bus.stall_o       = (idle && (bus.mem_wr_i || rd_miss)) || bus.ram_req_o
                               || (state_q == FILL);
    assign bus.rdata_o       = rd_hit              ? bus.cache_rdata_i :
                               (state_q == DONE)   ? data_q            : '0;

`ifdef DCACHE_STAT_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (rd_miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`else
    assign bus.hit_cnt_o  = '0;
    assign bus.miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl (TIMEOUT=15, default widths).
// Statistics expectations follow whether DCACHE_STAT_EN is defined.
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_rd_i      = 1'b0;
        bus.mem_wr_i      = 1'b0;
        bus.mem_addr_i    = '0;
        bus.mem_wdata_i   = '0;
        bus.cache_hit_i   = 1'b0;
        bus.cache_rdata_i = '0;
        bus.ram_ack_i     = 1'b0;
        bus.ram_rdata_i   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall: got %0b want 0", bus.stall_o); else n_pass++;
        n_checks++; if (bus.ram_req_o !== 1'b0) $display("FAIL reset_ram_req: got %0b want 0", bus.ram_req_o); else n_pass++;
        n_checks++; if (bus.cache_we_o !== 1'b0) $display("FAIL reset_cache_we: got %0b want 0", bus.cache_we_o); else n_pass++;
        n_checks++; if (bus.rdata_o !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", bus.rdata_o); else n_pass++;
        n_checks++; if (bus.bus_err_o !== 1'b0) $display("FAIL reset_bus_err: got %0b want 0", bus.bus_err_o); else n_pass++;
        cyc();
    endtask

    task automatic test_read_hit();
        bus.mem_rd_i = 1'b1; bus.mem_addr_i = 8'h14;
        bus.cache_hit_i = 1'b1; bus.cache_rdata_i = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (bus.rdata_o !== 16'hBEEF) $display("FAIL hit_rdata: got %h want BEEF", bus.rdata_o); else n_pass++;
        n_checks++; if (bus.stall_o !== 1'b0) $display("FAIL hit_stall: got %0b want 0", bus.stall_o); else n_pass++;
        n_checks++; if (bus.cache_addr_o !== 8'h14) $display("FAIL hit_cache_addr: got %h want 14", bus.cache_addr_o); else n_pass++;
        cyc();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.ram_req_o !== 1'b0) $display("FAIL hit_no_req: got %0b want 0", bus.ram_req_o); else n_pass++;
        n_checks++; if (bus.rdata_o !== 16'h0000) $display("FAIL hit_rdata_after: got %h want 0000", bus.rdata_o); else n_pass++;
        cyc();
    endtask

    task automatic test_read_miss();
        int stalls = 0;
        bus.mem_rd_i = 1'b1; bus.mem_addr_i = 8'h21; bus.cache_hit_i = 1'b0;
        @(negedge clk);
        stalls += int'(bus.stall_o);
        n_checks++; if (bus.ram_req_o !== 1'b0) $display("FAIL miss_idle_req: got %0b want 0", bus.ram_req_o); else n_pass++;
        cyc();
        @(negedge clk);
        stalls += int'(bus.stall_o);
        n_checks++; if (bus.ram_req_o !== 1'b1 || bus.ram_we_o !== 1'b0) $display("FAIL miss_req1: got req=%0b we=%0b want req=1 we=0", bus.ram_req_o, bus.ram_we_o); else n_pass++;
        n_checks++; if (bus.ram_addr_o !== 8'h21) $display("FAIL miss_ram_addr: got %h want 21", bus.ram_addr_o); else n_pass++;
        cyc();
        bus.ram_ack_i = 1'b1; bus.ram_rdata_i = 16'h1234;
        @(negedge clk);
        stalls += int'(bus.stall_o);
        n_checks++; if (bus.cache_we_o !== 1'b0) $display("FAIL miss_we_early: got %0b want 0", bus.cache_we_o); else n_pass++;
        cyc();
        bus.ram_ack_i = 1'b0; bus.ram_rdata_i = 16'h0000;
        @(negedge clk);
        stalls += int'(bus.stall_o);
        n_checks++; if (bus.cache_we_o !== 1'b1) $display("FAIL miss_fill_we: got %0b want 1", bus.cache_we_o); else n_pass++;
        n_checks++; if (bus.cache_wdata_o !== 16'h1234) $display("FAIL miss_fill_data: got %h want 1234", bus.cache_wdata_o); else n_pass++;
        n_checks++; if (bus.rdata_o !== 16'h0000) $display("FAIL miss_fill_rdata: got %h want 0000", bus.rdata_o); else n_pass++;
        cyc();
        @(negedge clk);
        stalls += int'(bus.stall_o);
        n_checks++; if (bus.rdata_o !== 16'h1234) $display("FAIL miss_done_rdata: got %h want 1234", bus.rdata_o); else n_pass++;
        n_checks++; if (bus.cache_we_o !== 1'b0) $display("FAIL miss_done_we: got %0b want 0", bus.cache_we_o); else n_pass++;
        n_checks++; if (stalls != 4) $display("FAIL miss_stall_cycles: got %0d want 4", stalls); else n_pass++;
        cyc();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.stall_o !== 1'b0 || bus.rdata_o !== 16'h0000) $display("FAIL miss_back_idle: got stall=%0b rdata=%h want 0/0000", bus.stall_o, bus.rdata_o); else n_pass++;
        cyc();
    endtask

    task automatic test_store();
        int stalls = 0;
        bit rd_req_seen = 1'b0;
        bus.mem_wr_i = 1'b1; bus.mem_rd_i = 1'b1;
        bus.mem_addr_i = 8'h07; bus.mem_wdata_i = 16'hA5A5; bus.cache_hit_i = 1'b0;
        @(negedge clk);
        stalls += int'(bus.stall_o);
        cyc();
        bus.ram_ack_i = 1'b1;
        @(negedge clk);
        stalls += int'(bus.stall_o);
        if (bus.ram_req_o && !bus.ram_we_o) rd_req_seen = 1'b1;
        n_checks++; if (bus.ram_req_o !== 1'b1 || bus.ram_we_o !== 1'b1) $display("FAIL st_req: got req=%0b we=%0b want 1/1", bus.ram_req_o, bus.ram_we_o); else n_pass++;
        n_checks++; if (bus.ram_addr_o !== 8'h07) $display("FAIL st_ram_addr: got %h want 07", bus.ram_addr_o); else n_pass++;
        n_checks++; if (bus.ram_wdata_o !== 16'hA5A5) $display("FAIL st_ram_wdata: got %h want A5A5", bus.ram_wdata_o); else n_pass++;
        cyc();
        bus.ram_ack_i = 1'b0;
        @(negedge clk);
        stalls += int'(bus.stall_o);
        if (bus.ram_req_o && !bus.ram_we_o) rd_req_seen = 1'b1;
        n_checks++; if (bus.cache_we_o !== 1'b1 || bus.cache_wdata_o !== 16'hA5A5) $display("FAIL st_fill: got we=%0b data=%h want 1/A5A5", bus.cache_we_o, bus.cache_wdata_o); else n_pass++;
        cyc();
        @(negedge clk);
        stalls += int'(bus.stall_o);
        if (bus.ram_req_o && !bus.ram_we_o) rd_req_seen = 1'b1;
        n_checks++; if (stalls != 3) $display("FAIL st_stall_cycles: got %0d want 3", stalls); else n_pass++;
        cyc();
        idle_inputs();
        @(negedge clk);
        if (bus.ram_req_o && !bus.ram_we_o) rd_req_seen = 1'b1;
        n_checks++; if (rd_req_seen !== 1'b0) $display("FAIL st_no_read_req: got %0b want 0", rd_req_seen); else n_pass++;
        cyc();
    endtask

    task automatic test_ack_ignored();
        bus.ram_ack_i = 1'b1; bus.ram_rdata_i = 16'h5555;
        cyc();
        bus.ram_ack_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.cache_we_o !== 1'b0 || bus.stall_o !== 1'b0) $display("FAIL ack_ignored: got we=%0b stall=%0b want 0/0", bus.cache_we_o, bus.stall_o); else n_pass++;
        cyc();
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        bit  we_seen = 1'b0;
        bus.mem_rd_i = 1'b1; bus.mem_addr_i = 8'h33; bus.cache_hit_i = 1'b0;
        cyc();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.ram_req_o) break;
            req_cycles++;
            if (bus.cache_we_o || bus.bus_err_o) we_seen = 1'b1;
            cyc();
        end
        n_checks++; if (req_cycles != 15) $display("FAIL tmo_req_cycles: got %0d want 15", req_cycles); else n_pass++;
        n_checks++; if (bus.bus_err_o !== 1'b1) $display("FAIL tmo_bus_err: got %0b want 1", bus.bus_err_o); else n_pass++;
        n_checks++; if (bus.rdata_o !== 16'hFFFF) $display("FAIL tmo_rdata: got %h want FFFF", bus.rdata_o); else n_pass++;
        n_checks++; if (bus.stall_o !== 1'b0 || bus.cache_we_o !== 1'b0) $display("FAIL tmo_done: got stall=%0b we=%0b want 0/0", bus.stall_o, bus.cache_we_o); else n_pass++;
        n_checks++; if (we_seen !== 1'b0) $display("FAIL tmo_early_we_or_err: got %0b want 0", we_seen); else n_pass++;
        cyc();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.bus_err_o !== 1'b0 || bus.ram_req_o !== 1'b0 || bus.cache_we_o !== 1'b0) $display("FAIL tmo_after: got err=%0b req=%0b we=%0b want 0/0/0", bus.bus_err_o, bus.ram_req_o, bus.cache_we_o); else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.mem_wr_i = 1'b1; bus.mem_addr_i = 8'h55; bus.mem_wdata_i = 16'h0F0F;
        cyc();
        @(negedge clk);
        n_checks++; if (bus.ram_req_o !== 1'b1) $display("FAIL rstmid_in_req: got %0b want 1", bus.ram_req_o); else n_pass++;
        idle_inputs();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.ram_req_o !== 1'b0 || bus.stall_o !== 1'b0) $display("FAIL rstmid_idle: got req=%0b stall=%0b want 0/0", bus.ram_req_o, bus.stall_o); else n_pass++;
        cyc();
        bus.ram_ack_i = 1'b1;
        cyc();
        bus.ram_ack_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.cache_we_o !== 1'b0 || bus.ram_req_o !== 1'b0) $display("FAIL rstmid_not_resumed: got we=%0b req=%0b want 0/0", bus.cache_we_o, bus.ram_req_o); else n_pass++;
        cyc();
    endtask

    task automatic run_miss(input logic [7:0] addr, input logic [15:0] data);
        bus.mem_rd_i = 1'b1; bus.mem_addr_i = addr; bus.cache_hit_i = 1'b0;
        cyc();
        bus.ram_ack_i = 1'b1; bus.ram_rdata_i = data;
        cyc();
        bus.ram_ack_i = 1'b0;
        cyc();
        cyc();
        idle_inputs();
    endtask

    task automatic test_stats();
        logic [15:0] exp_hit, exp_miss;
`ifdef DCACHE_STAT_EN
        exp_hit = 16'd3; exp_miss = 16'd2;
`else
        exp_hit = 16'd0; exp_miss = 16'd0;
`endif
        @(negedge clk);
        n_checks++; if (bus.hit_cnt_o !== 16'd0 || bus.miss_cnt_o !== 16'd0) $display("FAIL stat_cleared: got %0d/%0d want 0/0", bus.hit_cnt_o, bus.miss_cnt_o); else n_pass++;
        bus.mem_rd_i = 1'b1; bus.mem_addr_i = 8'h40; bus.cache_hit_i = 1'b1; bus.cache_rdata_i = 16'h0001;
        cyc();
        cyc();
        cyc();
        idle_inputs();
        run_miss(8'h61, 16'h00AA);
        run_miss(8'h62, 16'h00BB);
        @(negedge clk);
        n_checks++; if (bus.hit_cnt_o !== exp_hit) $display("FAIL stat_hit_cnt: got %0d want %0d", bus.hit_cnt_o, exp_hit); else n_pass++;
        n_checks++; if (bus.miss_cnt_o !== exp_miss) $display("FAIL stat_miss_cnt: got %0d want %0d", bus.miss_cnt_o, exp_miss); else n_pass++;
        cyc();
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_read_miss();
        test_store();
        test_ack_ignored();
        test_timeout();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
